// File: rtl/accumulator_ext.sv
// Accumulator (AC) with extension bit E for the processor datapath: single-cycle
// strobed operations plus a multi-cycle rotate-by-N engine over the {E,AC} ring.
module accumulator_ext #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             e_in,
   input  logic             clr,
   input  logic             ld,
   input  logic             inc,
   input  logic             add,
   input  logic             and_op,
   input  logic             cma,
   input  logic             cme,
   input  logic             cle,
   input  logic             cir,
   input  logic             cil,
   input  logic             rot_start,
   input  logic             rot_dir,
   input  logic [CNT_W-1:0] rot_cnt,
   output logic [WIDTH-1:0] data_out,
   output logic             e_out,
   output logic             busy,
   output logic             done,
   output logic             zero,
   output logic             sign
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_ROT  = 1'b1;

   logic [WIDTH-1:0] ac_q, ac_d;
   logic             e_q, e_d;
   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] cir_ac, cil_ac;
   logic             cir_e, cil_e;

   // One-bit circulate of the (WIDTH+1)-bit ring {E,AC}, shared by the strobes and the engine.
   assign sum    = {1'b0, ac_q} + {1'b0, data_in};
   assign cir_ac = {e_q, ac_q[WIDTH-1:1]};
   assign cir_e  = ac_q[0];
   assign cil_ac = {ac_q[WIDTH-2:0], e_q};
   assign cil_e  = ac_q[WIDTH-1];

   always_comb begin
      // NOTE: every next-state signal gets a hold default first so no path infers a latch.
      ac_d    = ac_q;
      e_d     = e_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (clr) begin
               ac_d = '0;
            end else if (ld) begin
               ac_d = data_in;
               e_d  = e_in;
            end else if (inc) begin
               ac_d = ac_q + WIDTH'(1);
            end else if (add) begin
               ac_d = sum[WIDTH-1:0];
               e_d  = sum[WIDTH];
            end else if (and_op) begin
               ac_d = ac_q & data_in;
            end else if (cma) begin
               ac_d = ~ac_q;
            end else if (cme) begin
               e_d = ~e_q;
            end else if (cle) begin
               e_d = 1'b0;
            end else if (cir) begin
               ac_d = cir_ac;
               e_d  = cir_e;
            end else if (cil) begin
               ac_d = cil_ac;
               e_d  = cil_e;
            end else if (rot_start) begin
               // A zero count finishes immediately: done pulses without ever going busy.
               if (rot_cnt != '0) begin
                  state_d = S_ROT;
                  cnt_d   = rot_cnt;
                  dir_d   = rot_dir;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_ROT: begin
            if (clr) begin
               ac_d    = '0;
               state_d = S_IDLE;
            end else begin
               ac_d  = dir_q ? cil_ac : cir_ac;
               e_d   = dir_q ? cil_e : cir_e;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all update together at the edge.
      if (rst) begin
         ac_q    <= '0;
         e_q     <= 1'b0;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         ac_q    <= ac_d;
         e_q     <= e_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
      end
   end

   assign data_out = ac_q;
   assign e_out    = e_q;
   assign busy     = (state_q == S_ROT);
   assign done     = done_q;
   assign zero     = (ac_q == '0);
   assign sign     = ac_q[WIDTH-1];

endmodule

// File: tb/tb_accumulator_ext.sv
// Directed bench for accumulator_ext: a vector table for the single-cycle commands
// plus hand-written sequences for the rotate engine, abort, reset and zero count.
module tb_accumulator_ext;

   localparam int WIDTH = 16;
   localparam int CNT_W = 5;

   localparam logic [9:0] C_CLR = 10'b1000000000;
   localparam logic [9:0] C_LD  = 10'b0100000000;
   localparam logic [9:0] C_INC = 10'b0010000000;
   localparam logic [9:0] C_ADD = 10'b0001000000;
   localparam logic [9:0] C_AND = 10'b0000100000;
   localparam logic [9:0] C_CMA = 10'b0000010000;
   localparam logic [9:0] C_CME = 10'b0000001000;
   localparam logic [9:0] C_CLE = 10'b0000000100;
   localparam logic [9:0] C_CIR = 10'b0000000010;
   localparam logic [9:0] C_CIL = 10'b0000000001;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] data_in;
   logic             e_in;
   logic             clr, ld, inc, add, and_op, cma, cme, cle, cir, cil;
   logic             rot_start, rot_dir;
   logic [CNT_W-1:0] rot_cnt;
   logic [WIDTH-1:0] data_out;
   logic             e_out, busy, done, zero, sign;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [9:0]       cmd;
      logic [WIDTH-1:0] din;
      logic             ein;
      logic [WIDTH-1:0] exp_ac;
      logic             exp_e;
   } vec_t;

   vec_t vecs[18];

   accumulator_ext #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .e_in(e_in),
      .clr(clr), .ld(ld), .inc(inc), .add(add), .and_op(and_op),
      .cma(cma), .cme(cme), .cle(cle), .cir(cir), .cil(cil),
      .rot_start(rot_start), .rot_dir(rot_dir), .rot_cnt(rot_cnt),
      .data_out(data_out), .e_out(e_out), .busy(busy), .done(done),
      .zero(zero), .sign(sign)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input logic [9:0] c);
      {clr, ld, inc, add, and_op, cma, cme, cle, cir, cil} = c;
   endtask

   task automatic load(input logic [WIDTH-1:0] v, input logic e);
      set_cmd(C_LD);
      data_in = v;
      e_in    = e;
      tick();
      set_cmd('0);
   endtask

   task automatic start_rot(input logic dir, input logic [CNT_W-1:0] n);
      rot_start = 1'b1;
      rot_dir   = dir;
      rot_cnt   = n;
      tick();
      rot_start = 1'b0;
   endtask

   function automatic vec_t mk(input logic [9:0] c, input logic [WIDTH-1:0] d, input logic ei,
                               input logic [WIDTH-1:0] ea, input logic ee);
      vec_t v;
      v.cmd = c; v.din = d; v.ein = ei; v.exp_ac = ea; v.exp_e = ee;
      return v;
   endfunction

   initial begin
      logic [16:0] ring;
      logic [16:0] exp_a[3];
      int          steps;
      int          dones;
      bit          finished;

      rst = 1'b1; data_in = '0; e_in = 1'b0; set_cmd('0);
      rot_start = 1'b0; rot_dir = 1'b0; rot_cnt = '0;
      tick(); tick();
      rst = 1'b0;
      check("rst_ac", data_out, 16'h0000);
      check("rst_e", e_out, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_zero", zero, 1'b1);

      // Vectors run back to back; each expectation assumes the state left by the previous one.
      vecs[0]  = mk(C_LD,          16'h8001, 1'b1, 16'h8001, 1'b1);
      vecs[1]  = mk(C_CIR,         16'h0000, 1'b0, 16'hC000, 1'b1);
      vecs[2]  = mk(C_CIL,         16'h0000, 1'b0, 16'h8001, 1'b1);
      vecs[3]  = mk(C_LD,          16'hFFFF, 1'b0, 16'hFFFF, 1'b0);
      vecs[4]  = mk(C_ADD,         16'h0001, 1'b0, 16'h0000, 1'b1);
      vecs[5]  = mk(C_INC,         16'h0000, 1'b0, 16'h0001, 1'b1);
      vecs[6]  = mk(C_AND,         16'h0000, 1'b0, 16'h0000, 1'b1);
      vecs[7]  = mk(C_CLR | C_LD,  16'h1234, 1'b0, 16'h0000, 1'b1);
      vecs[8]  = mk(C_LD | C_INC,  16'h00FF, 1'b0, 16'h00FF, 1'b0);
      vecs[9]  = mk(C_CME | C_CLE, 16'h0000, 1'b0, 16'h00FF, 1'b1);
      vecs[10] = mk(C_CMA,         16'h0000, 1'b0, 16'hFF00, 1'b1);
      vecs[11] = mk(C_CLE,         16'h0000, 1'b0, 16'hFF00, 1'b0);
      vecs[12] = mk(C_ADD,         16'h0100, 1'b0, 16'h0000, 1'b1);
      vecs[13] = mk(C_LD,          16'h1234, 1'b1, 16'h1234, 1'b1);
      vecs[14] = mk(C_ADD,         16'h0001, 1'b0, 16'h1235, 1'b0);
      vecs[15] = mk(C_AND,         16'h0F0F, 1'b0, 16'h0205, 1'b0);
      vecs[16] = mk(C_LD,          16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
      vecs[17] = mk(C_INC,         16'h0000, 1'b0, 16'h0000, 1'b1);

      foreach (vecs[i]) begin
         set_cmd(vecs[i].cmd);
         data_in = vecs[i].din;
         e_in    = vecs[i].ein;
         tick();
         set_cmd('0);
         check($sformatf("vec%0d_ac", i), data_out, vecs[i].exp_ac);
         check($sformatf("vec%0d_e", i), e_out, vecs[i].exp_e);
         check($sformatf("vec%0d_zero", i), zero, vecs[i].exp_ac == '0);
         check($sformatf("vec%0d_sign", i), sign, vecs[i].exp_ac[WIDTH-1]);
         check($sformatf("vec%0d_busy", i), busy, 1'b0);
      end

      // Rotate left by 3 from {0,8000}; then a command on the done cycle is accepted.
      load(16'h8000, 1'b0);
      start_rot(1'b1, 5'd3);
      check("rotA_busy0", busy, 1'b1);
      check("rotA_ac0", data_out, 16'h8000);
      exp_a[0] = 17'h10000; exp_a[1] = 17'h00001; exp_a[2] = 17'h00002;
      dones = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done) dones++;
         check($sformatf("rotA_step%0d", i), {e_out, data_out}, exp_a[i]);
         check($sformatf("rotA_busy%0d", i + 1), busy, i < 2);
      end
      check("rotA_dones", dones, 1);
      inc = 1'b1;
      tick();
      inc = 1'b0;
      check("rotA_done_fall", done, 1'b0);
      check("rotA_after_inc", data_out, 16'h0003);

      // Rotate left by 17 restores {1,1234}; strobes during the rotation are ignored.
      load(16'h1234, 1'b1);
      ring = 17'h11234;
      start_rot(1'b1, 5'd17);
      check("rotB_busy", busy, 1'b1);
      steps = 0;
      finished = 0;
      for (int c = 0; c < 40 && !finished; c++) begin
         ld = (c == 2); data_in = 16'hFFFF; cma = (c == 5);
         rot_start = (c == 8); rot_dir = 1'b0; rot_cnt = 5'd2;
         tick();
         set_cmd('0); rot_start = 1'b0;
         ring = {ring[15:0], ring[16]};
         steps++;
         check($sformatf("rotB_step%0d", steps), {e_out, data_out}, ring);
         if (done) finished = 1;
      end
      check("rotB_steps", steps, 17);
      check("rotB_final", {e_out, data_out}, 17'h11234);
      check("rotB_busy_end", busy, 1'b0);

      // Abort with clr on the second step of five: AC cleared, E kept, no done.
      load(16'h00F1, 1'b0);
      start_rot(1'b0, 5'd5);
      tick();
      check("abort_step1", {e_out, data_out}, 17'h10078);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("abort_ac", data_out, 16'h0000);
      check("abort_e", e_out, 1'b1);
      check("abort_busy", busy, 1'b0);
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         if (done) dones++;
         tick();
      end
      check("abort_no_done", dones, 0);

      // Reset in the middle of a rotation.
      load(16'hABCD, 1'b1);
      start_rot(1'b0, 5'd10);
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstmid_ac", data_out, 16'h0000);
      check("rstmid_e", e_out, 1'b0);
      check("rstmid_busy", busy, 1'b0);
      check("rstmid_done", done, 1'b0);
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) dones++;
      end
      check("rstmid_no_done", dones, 0);

      // Zero count: done pulses immediately, never busy, value unchanged.
      load(16'h5A5A, 1'b1);
      start_rot(1'b1, 5'd0);
      check("cnt0_busy", busy, 1'b0);
      check("cnt0_done", done, 1'b1);
      check("cnt0_val", {e_out, data_out}, 17'h15A5A);
      tick();
      check("cnt0_done_fall", done, 1'b0);
      check("cnt0_busy2", busy, 1'b0);
      check("cnt0_val2", {e_out, data_out}, 17'h15A5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
